// File: rtl/lcb_word_packer.sv
// LCB response packet framer: collects sync, data and checksum bytes from the UART
// and flushes a verified packet of 12-bit orbit words into the ping-pong buffer.
module lcb_word_packer #(
    parameter int unsigned WORDS     = 7,
    parameter logic [7:0]  SYNC      = 8'h7E,
    parameter logic [9:0]  BASE_ADDR = 10'd0,
    parameter logic [15:0] TIMEOUT   = 16'd8000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rxData,
    input  logic        rxValid,
    input  logic [4:0]  slot,
    output logic [11:0] wrdOut,
    output logic [9:0]  wrdAddr,
    output logic        wren,
    output logic        pktDone,
    output logic        pktErr,
    output logic [1:0]  errCode
);

    typedef enum logic [2:0] {IDLE, LO, HI, CSUM, FLUSH} state_t;

    localparam logic [3:0] LAST_IDX    = 4'(WORDS - 1);
    localparam logic [3:0] NUM_WORDS   = 4'(WORDS);
    localparam logic [1:0] ERR_FORMAT  = 2'd1;
    localparam logic [1:0] ERR_CSUM    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    state_t      state;
    logic        rx_prev;
    logic        byte_valid;
    logic [7:0]  byte_q;
    logic [3:0]  idx;
    logic [7:0]  lo_byte;
    logic [7:0]  xor_q;
    logic [15:0] timer;
    logic [9:0]  base_q;
    // Sized to the full 4-bit index range so idx selects without width games.
    logic [11:0] words [16];

    // One accepted byte per rxValid rising edge; edges landing in FLUSH are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_prev    <= 1'b0;
            byte_valid <= 1'b0;
            byte_q     <= '0;
        end else begin
            rx_prev    <= rxValid;
            byte_valid <= rxValid && !rx_prev && (state != FLUSH);
            if (rxValid && !rx_prev) begin
                byte_q <= rxData;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && byte_valid && state == HI && byte_q[7:4] == 4'h0) begin
            words[idx] <= {byte_q[3:0], lo_byte};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            idx     <= '0;
            lo_byte <= '0;
            xor_q   <= '0;
            timer   <= '0;
            base_q  <= '0;
            wrdOut  <= '0;
            wrdAddr <= '0;
            wren    <= 1'b0;
            pktDone <= 1'b0;
            pktErr  <= 1'b0;
            errCode <= '0;
        end else begin
            wren    <= 1'b0;
            pktDone <= 1'b0;
            pktErr  <= 1'b0;
            case (state)
                IDLE: begin
                    if (byte_valid && byte_q == SYNC) begin
                        base_q <= BASE_ADDR + 10'(slot) * 10'(WORDS);
                        idx    <= '0;
                        xor_q  <= '0;
                        timer  <= '0;
                        state  <= LO;
                    end
                end
                LO, HI, CSUM: begin
                    // An accepted byte beats a timeout expiring in the same cycle.
                    if (byte_valid) begin
                        timer <= '0;
                        if (state == LO) begin
                            lo_byte <= byte_q;
                            xor_q   <= xor_q ^ byte_q;
                            state   <= HI;
                        end else if (state == HI) begin
                            if (byte_q[7:4] != 4'h0) begin
                                pktErr  <= 1'b1;
                                errCode <= ERR_FORMAT;
                                state   <= IDLE;
                            end else begin
                                xor_q <= xor_q ^ byte_q;
                                if (idx == LAST_IDX) begin
                                    state <= CSUM;
                                end else begin
                                    idx   <= idx + 4'd1;
                                    state <= LO;
                                end
                            end
                        end else begin
                            if (byte_q == xor_q) begin
                                idx   <= '0;
                                state <= FLUSH;
                            end else begin
                                pktErr  <= 1'b1;
                                errCode <= ERR_CSUM;
                                state   <= IDLE;
                            end
                        end
                    end else if (timer == TIMEOUT - 16'd1) begin
                        pktErr  <= 1'b1;
                        errCode <= ERR_TIMEOUT;
                        state   <= IDLE;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                FLUSH: begin
                    if (idx < NUM_WORDS) begin
                        wren    <= 1'b1;
                        wrdOut  <= words[idx];
                        wrdAddr <= base_q + 10'(idx);
                        idx     <= idx + 4'd1;
                    end else begin
                        pktDone <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcb_word_packer.sv
// Bench for lcb_word_packer: drives UART-style byte streams into two instances
// (default base and BASE_ADDR=900) and scores the buffer writes against a packet model.
module tb_lcb_word_packer;

    localparam int         WORDS   = 7;
    localparam int         TIMEOUT = 8000;
    localparam int         BASE_B  = 900;
    localparam logic [7:0] SYNC    = 8'h7E;

    logic        clk     = 1'b0;
    logic        reset   = 1'b1;
    logic [7:0]  rxData  = '0;
    logic        rxValid = 1'b0;
    logic [4:0]  slot    = '0;

    logic [11:0] a_wrdOut, b_wrdOut;
    logic [9:0]  a_wrdAddr, b_wrdAddr;
    logic        a_wren, b_wren, a_pktDone, b_pktDone, a_pktErr, b_pktErr;
    logic [1:0]  a_errCode, b_errCode;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int last_raise  = 0;
    int last_err    = 0;

    int a_addr[$], a_data[$], a_wcyc[$];
    int b_addr[$], b_data[$];
    int a_done = 0, a_done_cyc = 0, a_err = 0, a_err_cyc = 0;
    int b_done = 0, b_err = 0;

    logic [7:0] pkt [2*WORDS];
    int exp_addr [WORDS];
    int exp_data [WORDS];

    lcb_word_packer dut_a (
        .clk(clk), .reset(reset), .rxData(rxData), .rxValid(rxValid), .slot(slot),
        .wrdOut(a_wrdOut), .wrdAddr(a_wrdAddr), .wren(a_wren), .pktDone(a_pktDone),
        .pktErr(a_pktErr), .errCode(a_errCode)
    );

    lcb_word_packer #(.BASE_ADDR(10'd900)) dut_b (
        .clk(clk), .reset(reset), .rxData(rxData), .rxValid(rxValid), .slot(slot),
        .wrdOut(b_wrdOut), .wrdAddr(b_wrdAddr), .wren(b_wren), .pktDone(b_pktDone),
        .pktErr(b_pktErr), .errCode(b_errCode)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every write and pulse on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (a_wren) begin
            a_addr.push_back(int'(a_wrdAddr));
            a_data.push_back(int'(a_wrdOut));
            a_wcyc.push_back(cyc);
        end
        if (b_wren) begin
            b_addr.push_back(int'(b_wrdAddr));
            b_data.push_back(int'(b_wrdOut));
        end
        if (a_pktDone) begin a_done++; a_done_cyc = cyc; end
        if (a_pktErr)  begin a_err++;  a_err_cyc  = cyc; end
        if (b_pktDone) b_done++;
        if (b_pktErr)  b_err++;
    end

    task automatic clear_monitors();
        a_addr.delete(); a_data.delete(); a_wcyc.delete();
        b_addr.delete(); b_data.delete();
        a_done = 0; a_err = 0; b_done = 0; b_err = 0;
    endtask

    // rxValid high for 'hold' cycles, then low for 'gap' cycles before the next byte.
    task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
        @(negedge clk);
        rxData     = b;
        rxValid    = 1'b1;
        last_raise = cyc;
        repeat (hold) begin
            @(negedge clk);
            rxData = 8'($urandom);
        end
        rxValid = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    function automatic logic [7:0] calc_csum();
        logic [7:0] x = 8'h00;
        foreach (pkt[i]) x = x ^ pkt[i];
        return x;
    endfunction

    task automatic send_packet(input int sl, input int hold, input int gap, input logic [7:0] flip);
        slot = 5'(sl);
        send_byte(SYNC, hold, gap);
        foreach (pkt[i]) send_byte(pkt[i], hold, gap);
        send_byte(calc_csum() ^ flip, hold, gap);
    endtask

    task automatic fill_case1();
        pkt = '{8'h34, 8'h01, 8'h56, 8'h02, 8'h78, 8'h03, 8'h9A, 8'h04,
                8'hBC, 8'h05, 8'hDE, 8'h06, 8'hF0, 8'h07};
    endtask

    task automatic fill_random();
        for (int i = 0; i < WORDS; i++) begin
            pkt[2*i]   = 8'($urandom_range(0, 255));
            pkt[2*i+1] = 8'($urandom_range(0, 15));
        end
    endtask

    task automatic build_expect(input int base, input int sl);
        for (int i = 0; i < WORDS; i++) begin
            exp_data[i] = (int'(pkt[2*i+1]) % 16) * 256 + int'(pkt[2*i]);
            exp_addr[i] = (base + sl * WORDS + i) % 1024;
        end
    endtask

    task automatic settle();
        repeat (30) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        vectors += 6;
        if (a_wrdOut !== 12'd0) begin miscompares++; $display("[TB] FAIL reset_wrdOut: got %0h expected 0", a_wrdOut); end
        if (a_wrdAddr !== 10'd0) begin miscompares++; $display("[TB] FAIL reset_wrdAddr: got %0d expected 0", a_wrdAddr); end
        if (a_wren !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_wren: got %0b expected 0", a_wren); end
        if (a_pktDone !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_pktDone: got %0b expected 0", a_pktDone); end
        if (a_pktErr !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_pktErr: got %0b expected 0", a_pktErr); end
        if (a_errCode !== 2'd0) begin miscompares++; $display("[TB] FAIL reset_errCode: got %0d expected 0", a_errCode); end
        reset = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_good_packet();
        fill_case1();
        clear_monitors();
        send_packet(0, 1, 2, 8'h00);
        settle();
        build_expect(0, 0);
        vectors++;
        if (a_addr.size() !== WORDS) begin miscompares++; $display("[TB] FAIL good_count: got %0d expected %0d", a_addr.size(), WORDS); end
        for (int i = 0; i < WORDS && i < a_addr.size(); i++) begin
            vectors += 3;
            if (a_addr[i] !== exp_addr[i]) begin miscompares++; $display("[TB] FAIL good_addr[%0d]: got %0d expected %0d", i, a_addr[i], exp_addr[i]); end
            if (a_data[i] !== exp_data[i]) begin miscompares++; $display("[TB] FAIL good_data[%0d]: got %0h expected %0h", i, a_data[i], exp_data[i]); end
            if (a_wcyc[i] !== last_raise + 3 + i) begin miscompares++; $display("[TB] FAIL good_wr_cycle[%0d]: got %0d expected %0d", i, a_wcyc[i], last_raise + 3 + i); end
        end
        vectors += 4;
        if (a_done !== 1) begin miscompares++; $display("[TB] FAIL good_done_count: got %0d expected 1", a_done); end
        if (a_done_cyc !== last_raise + 3 + WORDS) begin miscompares++; $display("[TB] FAIL good_done_cycle: got %0d expected %0d", a_done_cyc, last_raise + 3 + WORDS); end
        if (a_err !== 0) begin miscompares++; $display("[TB] FAIL good_err_count: got %0d expected 0", a_err); end
        if (a_errCode !== 2'(last_err)) begin miscompares++; $display("[TB] FAIL good_errCode: got %0d expected %0d", a_errCode, last_err); end
    endtask

    task automatic test_checksum_error();
        fill_case1();
        clear_monitors();
        send_packet(0, 1, 2, 8'h01);
        settle();
        last_err = 2;
        vectors += 5;
        if (a_addr.size() !== 0) begin miscompares++; $display("[TB] FAIL csum_writes: got %0d expected 0", a_addr.size()); end
        if (a_done !== 0) begin miscompares++; $display("[TB] FAIL csum_done: got %0d expected 0", a_done); end
        if (a_err !== 1) begin miscompares++; $display("[TB] FAIL csum_err_count: got %0d expected 1", a_err); end
        if (a_err_cyc !== last_raise + 2) begin miscompares++; $display("[TB] FAIL csum_err_cycle: got %0d expected %0d", a_err_cyc, last_raise + 2); end
        if (a_errCode !== 2'(last_err)) begin miscompares++; $display("[TB] FAIL csum_errCode: got %0d expected %0d", a_errCode, last_err); end
        // A good packet afterwards writes normally and leaves errCode alone.
        test_good_packet();
    endtask

    task automatic test_format_error();
        int fmt_raise;
        fill_case1();
        pkt[1] = 8'h1F;
        clear_monitors();
        slot = '0;
        send_byte(SYNC, 1, 2);
        send_byte(pkt[0], 1, 2);
        send_byte(pkt[1], 1, 2);
        fmt_raise = last_raise;
        for (int i = 2; i < 2*WORDS; i++) send_byte(pkt[i], 1, 2);
        send_byte(calc_csum(), 1, 2);
        settle();
        last_err = 1;
        vectors += 5;
        if (a_err !== 1) begin miscompares++; $display("[TB] FAIL fmt_err_count: got %0d expected 1", a_err); end
        if (a_err_cyc !== fmt_raise + 2) begin miscompares++; $display("[TB] FAIL fmt_err_cycle: got %0d expected %0d", a_err_cyc, fmt_raise + 2); end
        if (a_errCode !== 2'(last_err)) begin miscompares++; $display("[TB] FAIL fmt_errCode: got %0d expected %0d", a_errCode, last_err); end
        if (a_addr.size() !== 0) begin miscompares++; $display("[TB] FAIL fmt_writes: got %0d expected 0", a_addr.size()); end
        if (a_done !== 0) begin miscompares++; $display("[TB] FAIL fmt_done: got %0d expected 0", a_done); end
        test_good_packet();
    endtask

    task automatic test_random_packets();
        int sl, hold, gap;
        for (int p = 0; p < 8; p++) begin
            fill_random();
            if (p % 3 == 1) pkt[2*(p % WORDS)] = SYNC;
            sl   = $urandom_range(0, 31);
            hold = $urandom_range(1, 3);
            gap  = $urandom_range(1, 4);
            clear_monitors();
            send_packet(sl, hold, gap, 8'h00);
            settle();
            build_expect(0, sl);
            vectors += 3;
            if (a_addr.size() !== WORDS) begin miscompares++; $display("[TB] FAIL rand%0d_count: got %0d expected %0d", p, a_addr.size(), WORDS); end
            if (a_done !== 1) begin miscompares++; $display("[TB] FAIL rand%0d_done: got %0d expected 1", p, a_done); end
            if (a_err !== 0) begin miscompares++; $display("[TB] FAIL rand%0d_err: got %0d expected 0", p, a_err); end
            for (int i = 0; i < WORDS && i < a_addr.size(); i++) begin
                vectors += 2;
                if (a_addr[i] !== exp_addr[i]) begin miscompares++; $display("[TB] FAIL rand%0d_addr[%0d]: got %0d expected %0d", p, i, a_addr[i], exp_addr[i]); end
                if (a_data[i] !== exp_data[i]) begin miscompares++; $display("[TB] FAIL rand%0d_data[%0d]: got %0h expected %0h", p, i, a_data[i], exp_data[i]); end
            end
            build_expect(BASE_B, sl);
            vectors++;
            if (b_addr.size() !== WORDS) begin miscompares++; $display("[TB] FAIL rand%0d_b_count: got %0d expected %0d", p, b_addr.size(), WORDS); end
            for (int i = 0; i < WORDS && i < b_addr.size(); i++) begin
                vectors += 2;
                if (b_addr[i] !== exp_addr[i]) begin miscompares++; $display("[TB] FAIL rand%0d_b_addr[%0d]: got %0d expected %0d", p, i, b_addr[i], exp_addr[i]); end
                if (b_data[i] !== exp_data[i]) begin miscompares++; $display("[TB] FAIL rand%0d_b_data[%0d]: got %0h expected %0h", p, i, b_data[i], exp_data[i]); end
            end
        end
    endtask

    task automatic test_timeout();
        int gaps [3];
        int stall_raise;
        bit expect_err;
        gaps = '{TIMEOUT - 2, TIMEOUT - 1, TIMEOUT};
        foreach (gaps[g]) begin
            expect_err = (gaps[g] >= TIMEOUT);
            fill_case1();
            clear_monitors();
            slot = 5'd3;
            send_byte(SYNC, 1, 2);
            send_byte(pkt[0], 1, 2);
            send_byte(pkt[1], 1, 2);
            send_byte(pkt[2], 1, gaps[g]);
            stall_raise = last_raise;
            for (int i = 3; i < 2*WORDS; i++) send_byte(pkt[i], 1, 2);
            send_byte(calc_csum(), 1, 2);
            settle();
            build_expect(0, 3);
            if (expect_err) last_err = 3;
            vectors += 3;
            if (a_err !== (expect_err ? 1 : 0)) begin miscompares++; $display("[TB] FAIL tmo%0d_err_count: got %0d expected %0d", gaps[g], a_err, expect_err ? 1 : 0); end
            if (a_addr.size() !== (expect_err ? 0 : WORDS)) begin miscompares++; $display("[TB] FAIL tmo%0d_writes: got %0d expected %0d", gaps[g], a_addr.size(), expect_err ? 0 : WORDS); end
            if (a_errCode !== 2'(last_err)) begin miscompares++; $display("[TB] FAIL tmo%0d_errCode: got %0d expected %0d", gaps[g], a_errCode, last_err); end
            if (expect_err) begin
                vectors++;
                if (a_err_cyc !== stall_raise + 2 + TIMEOUT) begin miscompares++; $display("[TB] FAIL tmo%0d_err_cycle: got %0d expected %0d", gaps[g], a_err_cyc, stall_raise + 2 + TIMEOUT); end
            end
            for (int i = 0; i < WORDS && i < a_addr.size(); i++) begin
                vectors += 2;
                if (a_addr[i] !== exp_addr[i]) begin miscompares++; $display("[TB] FAIL tmo%0d_addr[%0d]: got %0d expected %0d", gaps[g], i, a_addr[i], exp_addr[i]); end
                if (a_data[i] !== exp_data[i]) begin miscompares++; $display("[TB] FAIL tmo%0d_data[%0d]: got %0h expected %0h", gaps[g], i, a_data[i], exp_data[i]); end
            end
        end
    endtask

    task automatic test_long_hold();
        fill_case1();
        clear_monitors();
        slot = '0;
        for (int k = 0; k < 3; k++) send_byte(8'($urandom_range(0, 125)), 10, 3);
        send_packet(0, 10, 3, 8'h00);
        settle();
        build_expect(0, 0);
        vectors += 3;
        if (a_addr.size() !== WORDS) begin miscompares++; $display("[TB] FAIL hold_count: got %0d expected %0d", a_addr.size(), WORDS); end
        if (a_done !== 1) begin miscompares++; $display("[TB] FAIL hold_done: got %0d expected 1", a_done); end
        if (a_err !== 0) begin miscompares++; $display("[TB] FAIL hold_err: got %0d expected 0", a_err); end
        for (int i = 0; i < WORDS && i < a_addr.size(); i++) begin
            vectors += 2;
            if (a_addr[i] !== exp_addr[i]) begin miscompares++; $display("[TB] FAIL hold_addr[%0d]: got %0d expected %0d", i, a_addr[i], exp_addr[i]); end
            if (a_data[i] !== exp_data[i]) begin miscompares++; $display("[TB] FAIL hold_data[%0d]: got %0h expected %0h", i, a_data[i], exp_data[i]); end
        end
    endtask

    task automatic test_wrap_and_reset();
        int r;
        fill_random();
        clear_monitors();
        send_packet(31, 1, 2, 8'h00);
        settle();
        build_expect(BASE_B, 31);
        vectors += 2;
        if (b_addr.size() !== WORDS) begin miscompares++; $display("[TB] FAIL wrap_count: got %0d expected %0d", b_addr.size(), WORDS); end
        if (b_done !== 1) begin miscompares++; $display("[TB] FAIL wrap_done: got %0d expected 1", b_done); end
        for (int i = 0; i < WORDS && i < b_addr.size(); i++) begin
            vectors += 2;
            if (b_addr[i] !== exp_addr[i]) begin miscompares++; $display("[TB] FAIL wrap_addr[%0d]: got %0d expected %0d", i, b_addr[i], exp_addr[i]); end
            if (b_data[i] !== exp_data[i]) begin miscompares++; $display("[TB] FAIL wrap_data[%0d]: got %0h expected %0h", i, b_data[i], exp_data[i]); end
        end

        // Same packet again, with reset landing on the third flush write.
        clear_monitors();
        slot = 5'd31;
        send_byte(SYNC, 1, 2);
        foreach (pkt[i]) send_byte(pkt[i], 1, 2);
        @(negedge clk);
        rxData  = calc_csum();
        rxValid = 1'b1;
        r       = cyc;
        @(negedge clk);
        rxValid = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        vectors += 6;
        if (b_wren !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_wren: got %0b expected 0 (cycle %0d)", b_wren, cyc - r); end
        if (b_pktDone !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_pktDone: got %0b expected 0", b_pktDone); end
        if (b_pktErr !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_pktErr: got %0b expected 0", b_pktErr); end
        if (b_wrdOut !== 12'd0) begin miscompares++; $display("[TB] FAIL rst_wrdOut: got %0h expected 0", b_wrdOut); end
        if (b_wrdAddr !== 10'd0) begin miscompares++; $display("[TB] FAIL rst_wrdAddr: got %0d expected 0", b_wrdAddr); end
        if (b_errCode !== 2'd0) begin miscompares++; $display("[TB] FAIL rst_errCode: got %0d expected 0", b_errCode); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        settle();
        vectors += 2;
        if (b_addr.size() !== 3) begin miscompares++; $display("[TB] FAIL rst_writes: got %0d expected 3", b_addr.size()); end
        if (b_done !== 0) begin miscompares++; $display("[TB] FAIL rst_done: got %0d expected 0", b_done); end
        for (int i = 0; i < 3 && i < b_addr.size(); i++) begin
            vectors += 2;
            if (b_addr[i] !== exp_addr[i]) begin miscompares++; $display("[TB] FAIL rst_addr[%0d]: got %0d expected %0d", i, b_addr[i], exp_addr[i]); end
            if (b_data[i] !== exp_data[i]) begin miscompares++; $display("[TB] FAIL rst_data[%0d]: got %0h expected %0h", i, b_data[i], exp_data[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_good_packet();
        test_checksum_error();
        test_format_error();
        test_random_packets();
        test_timeout();
        test_long_hold();
        test_wrap_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
